// File: rtl/crc_pkg.sv
// Shared definitions for the CRC-32 frame sequencer and its byte engine.
//   - Frame sequencer state encoding (IDLE=0, CLR=1, DATA=2, FCS=3)
//   - FCS_BYTES: number of FCS bytes appended per frame
//   - crc32_byte(): one byte step of the reflected CRC-32 (poly 0xEDB88320)
package crc_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CLR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_FCS  = 2'd3;

  localparam int unsigned FCS_BYTES = 4;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;

  // LSB-first (reflected) update: the byte is consumed bit 0 first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  din);
    logic [31:0] c;
    c = crc ^ {24'h0, din};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc.sv
// Byte-wide CRC-32 engine (Ethernet FCS).
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous, active-high; preloads the register to all ones
//   en      in   consume din this cycle
//   din     in   8-bit data byte
//   crc_out out  final (complemented) CRC, byte-swapped so that
//                crc_out[31:24] is the first FCS byte on the wire
module crc
  import crc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] crc_out
);

  logic [31:0] r_crc;
  logic [31:0] w_fin;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_crc <= '1;
    end else if (en) begin
      r_crc <= crc32_byte(r_crc, din);
    end
  end

  // The reflected CRC's low byte is transmitted first; place it in the MSBs.
  assign w_fin   = ~r_crc;
  assign crc_out = {w_fin[7:0], w_fin[15:8], w_fin[23:16], w_fin[31:24]};

endmodule

// File: rtl/crc_frame_ctrl.sv
// Frame sequencer for the byte-wide CRC-32 engine. Forwards each input frame
// unchanged on a registered output stage and appends the 4-byte FCS.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   s_valid/s_ready/s_data/s_last   input byte stream
//   m_valid/m_ready/m_data/m_last   output byte stream (payload then FCS)
//   crc_value               FCS of the most recently completed frame
//   crc_done                one-cycle pulse after the last FCS byte handshake
//   frame_cnt               completed frame count (wraps)
module crc_frame_ctrl
  import crc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_last,
  output logic [31:0]      crc_value,
  output logic             crc_done,
  output logic [CNT_W-1:0] frame_cnt
);

  logic [1:0]       r_state;
  logic [1:0]       r_idx;
  logic             r_crc_clr;
  logic             r_m_valid;
  logic [7:0]       r_m_data;
  logic             r_m_last;
  logic [31:0]      r_crc_value;
  logic             r_crc_done;
  logic [CNT_W-1:0] r_frame_cnt;

  logic             w_out_free;
  logic             w_s_hs;
  logic             w_crc_rst;
  logic [31:0]      w_crc_out;
  logic [7:0]       w_fcs_byte;

  assign w_out_free = !r_m_valid || m_ready;
  assign s_ready    = (r_state == ST_DATA) && w_out_free;
  assign w_s_hs     = s_valid && s_ready;
  assign w_crc_rst  = r_crc_clr | ~reset_n;

  crc u_crc (
    .clk     (clk),
    .reset   (w_crc_rst),
    .en      (w_s_hs),
    .din     (s_data),
    .crc_out (w_crc_out)
  );

  always_comb begin
    w_fcs_byte = w_crc_out[31:24];
    case (r_idx)
      2'd1:    w_fcs_byte = w_crc_out[23:16];
      2'd2:    w_fcs_byte = w_crc_out[15:8];
      2'd3:    w_fcs_byte = w_crc_out[7:0];
      default: w_fcs_byte = w_crc_out[31:24];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_crc_clr   <= 1'b0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_m_last    <= 1'b0;
      r_crc_value <= '0;
      r_crc_done  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_crc_clr  <= 1'b0;
      r_crc_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (s_valid) begin
            r_state   <= ST_CLR;
            r_crc_clr <= 1'b1;
          end
        end
        ST_CLR: begin
          r_state <= ST_DATA;
        end
        ST_DATA: begin
          if (w_s_hs) begin
            r_m_data  <= s_data;
            r_m_valid <= 1'b1;
            r_m_last  <= 1'b0;
            if (s_last) begin
              r_state <= ST_FCS;
              r_idx   <= '0;
            end
          end else if (m_ready) begin
            r_m_valid <= 1'b0;
          end
        end
        ST_FCS: begin
          // The final byte is already loaded once m_last is up; only its
          // handshake remains before closing the frame.
          if (r_m_valid && r_m_last) begin
            if (m_ready) begin
              r_m_valid   <= 1'b0;
              r_m_last    <= 1'b0;
              r_state     <= ST_IDLE;
              r_crc_value <= w_crc_out;
              r_crc_done  <= 1'b1;
              r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
          end else if (w_out_free) begin
            r_m_data  <= w_fcs_byte;
            r_m_valid <= 1'b1;
            r_m_last  <= (r_idx == 2'(FCS_BYTES - 1));
            r_idx     <= r_idx + 2'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign m_last    = r_m_last;
  assign crc_value = r_crc_value;
  assign crc_done  = r_crc_done;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Scoreboard bench for crc_frame_ctrl: the driver pushes expected output
// bytes and FCS values as it issues frames; a negedge monitor pops and
// compares whenever the DUT hands over a byte or pulses crc_done.
module tb_crc_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = '0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [7:0]  m_data;
  logic        m_last;
  logic [31:0] crc_value;
  logic        crc_done;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  crc_frame_ctrl #(.CNT_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .crc_value (crc_value),
    .crc_done  (crc_done),
    .frame_cnt (frame_cnt)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } obyte_t;

  obyte_t      exp_q[$];
  logic [31:0] crc_q[$];
  logic [31:0] got_crc[$];
  int          checks = 0;
  int          errors = 0;
  int          pending_done = 0;
  int          done_pulses = 0;
  logic [15:0] cnt_model = '0;
  bit          rdy_rand = 1'b0;
  bit          in_tail = 1'b0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;
  logic        prev_last = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Standard Ethernet CRC-32 of the frame, returned as the 4 wire bytes
  // (first transmitted byte in bits 31:24).
  function automatic logic [31:0] wire_fcs(input logic [7:0] f[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (f[i]) begin
      c = c ^ {24'h0, f[i]};
      for (int b = 0; b < 8; b++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    return {c[7:0], c[15:8], c[23:16], c[31:24]};
  endfunction

  // m_ready: always 1, or a fresh 50% coin each cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_s_ready",   s_ready,   0);
      check("rst_m_valid",   m_valid,   0);
      check("rst_m_data",    m_data,    0);
      check("rst_m_last",    m_last,    0);
      check("rst_crc_value", crc_value, 0);
      check("rst_crc_done",  crc_done,  0);
      check("rst_frame_cnt", frame_cnt, 0);
      exp_q.delete();
      crc_q.delete();
      pending_done = 0;
      cnt_model    = '0;
      in_tail      = 1'b0;
      prev_stall   = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_m_valid", m_valid, 1);
        check("stall_m_data",  m_data,  prev_data);
        check("stall_m_last",  m_last,  prev_last);
      end
      if (m_valid && !m_ready) check("stall_s_ready", s_ready, 0);
      if (in_tail) check("s_ready_in_fcs", s_ready, 0);
      if (s_valid && s_ready && s_last) in_tail = 1'b1;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none", m_data);
        end else begin
          obyte_t e;
          e = exp_q.pop_front();
          check("m_data", m_data, e.data);
          check("m_last", m_last, e.last);
        end
        if (m_last) begin
          in_tail = 1'b0;
          pending_done++;
        end
      end
      if (crc_done) begin
        done_pulses++;
        got_crc.push_back(crc_value);
        check("done_after_last", pending_done > 0, 1);
        if (pending_done > 0) pending_done--;
        if (crc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: got crc %0h expected no pulse", crc_value);
        end else begin
          check("crc_value", crc_value, crc_q.pop_front());
        end
        cnt_model = cnt_model + 16'd1;
        check("frame_cnt", frame_cnt, cnt_model);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit last, output int waits);
    s_valid = 1'b1;
    s_data  = b;
    s_last  = last;
    waits   = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      waits++;
      if (waits >= 200) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout: got no s_ready expected s_ready within 200 cycles");
        $fatal(1, "input handshake never completed");
      end
    end
    exp_q.push_back('{data: b, last: 1'b0});
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit chk_start, input bit hold);
    int          w;
    logic [31:0] v;
    for (int i = 0; i < f.size(); i++) begin
      send_byte(f[i], i == f.size() - 1, w);
      if (chk_start && i == 0) check("start_overhead", w, 2);
    end
    v = wire_fcs(f);
    crc_q.push_back(v);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back('{data: v[31:24], last: (k == 3)});
      v = v << 8;
    end
    if (!hold) begin
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || crc_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d bytes pending expected 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] f1234[$];
    logic [7:0] f9[$];
    logic [7:0] f1[$];
    logic [7:0] fr[$];
    int         d0;
    int         w;

    f1234 = '{8'h31, 8'h32, 8'h33, 8'h34};
    f9    = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    f1    = '{8'h31};

    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // "1234" then "123456789" back to back; s_valid stays up through the FCS.
    rdy_rand = 1'b0;
    send_frame(f1234, 1'b1, 1'b1);
    send_frame(f9, 1'b0, 1'b0);
    wait_drain();
    check("n_done_pair", got_crc.size(), 2);
    if (got_crc.size() == 2) begin
      check("crc_1234", got_crc[0], 32'hA3E0E39B);
      check("crc_123456789", got_crc[1], 32'h2639F4CB);
    end
    check("frame_cnt_pair", frame_cnt, 2);
    got_crc.delete();

    // "1234" with a 50% random m_ready.
    rdy_rand = 1'b1;
    send_frame(f1234, 1'b1, 1'b0);
    wait_drain();
    check("crc_1234_stall", crc_value, 32'hA3E0E39B);
    rdy_rand = 1'b0;

    // 1-byte frame: exactly one crc_done.
    d0 = done_pulses;
    send_frame(f1, 1'b1, 1'b0);
    wait_drain();
    repeat (5) @(posedge clk);
    #1;
    check("one_byte_done_count", done_pulses - d0, 1);

    // Reset after byte 2 of "1234", then a clean "1234".
    send_byte(8'h31, 1'b0, w);
    send_byte(8'h32, 1'b0, w);
    s_valid = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(f1234, 1'b1, 1'b0);
    wait_drain();
    check("crc_after_reset", crc_value, 32'hA3E0E39B);
    check("frame_cnt_after_reset", frame_cnt, 1);

    // Random frames, random backpressure, random gaps or back-to-back.
    for (int n = 0; n < 24; n++) begin
      int len;
      bit hold;
      len = $urandom_range(1, 16);
      fr.delete();
      for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
      rdy_rand = 1'($urandom_range(0, 1));
      hold     = 1'($urandom_range(0, 1));
      send_frame(fr, 1'b0, hold);
      if (!hold) repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    s_valid  = 1'b0;
    s_last   = 1'b0;
    wait_drain();
    rdy_rand = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Counter wrap from 0xFFFF.
    force dut.r_frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_frame_cnt;
    cnt_model = 16'hFFFF;
    @(posedge clk);
    #1;
    send_frame(f1234, 1'b1, 1'b0);
    wait_drain();
    check("frame_cnt_wrap", frame_cnt, 0);

    check("pending_done_end", pending_done, 0);
    check("exp_q_empty_end", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
